egress_read_sched: RTL and testbench

- Read-side scheduler for the multi-queue async egress FIFO, clocked in the clk2 (consumer) domain.
- Selects one eligible queue at a time, round-robin, and drives the FIFO's read_adr, read_data and read_enable controls.
- Issues a fixed-length burst or a single word, per queue fill state.
- Produces a pipelined valid/queue-id/last side-band, aligned with the FIFO's registered output q, for the downstream consumer.

---
 rtl/egress_read_sched_if.sv | 28 ++
 rtl/egress_read_sched.sv | 172 +++++++++++++++++
 tb/tb_egress_read_sched.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/egress_read_sched_if.sv
// Control and side-band bundle between the egress read scheduler, the async
// egress FIFO read port and the downstream consumer.
interface egress_read_sched_if #(
    parameter int nr_of_queues = 16,
    parameter int a_lo_size    = 4
);
    logic                    enable;
    logic [0:nr_of_queues-1] fifo_empty;
    logic [0:nr_of_queues-1] fifo_flag;
    logic [0:nr_of_queues-1] ready;
    logic                    read_adr;
    logic                    read_data;
    logic [0:nr_of_queues-1] read_enable;
    logic                    q_valid;
    logic [a_lo_size-1:0]    q_queue;
    logic                    q_last;
    logic                    busy;

    modport master (
        input  enable, fifo_empty, fifo_flag, ready,
        output read_adr, read_data, read_enable, q_valid, q_queue, q_last, busy
    );

    modport slave (
        output enable, fifo_empty, fifo_flag, ready,
        input  read_adr, read_data, read_enable, q_valid, q_queue, q_last, busy
    );
endinterface

// File: rtl/egress_read_sched.sv
// Round-robin read scheduler for the multi-queue egress FIFO (clk2 domain):
// grants a burst or single word per queue and tracks popped words to q.
//
// state | meaning
// IDLE  | no grant; arbitrate among eligible queues
// ADR   | one-cycle read_adr strobe to the selected queue
// AWAIT | FIFO pops word 0 via its registered read_adr; read_data held low
// DATA  | read_data pops the remaining L-1 words
module egress_read_sched #(
    parameter int nr_of_queues = 16,
    parameter int a_lo_size    = 4,
    parameter int burst_len    = 4,
    parameter int rd_lat       = 2,
    parameter int holdoff      = 3
) (
    input logic                 clk2,
    input logic                 rst2,
    egress_read_sched_if.master bus
);
    localparam int hw = $clog2(holdoff + 2);

    typedef enum logic [1:0] {IDLE, ADR, AWAIT, DATA} state_t;

    state_t                  state;
    logic [a_lo_size-1:0]    ptr;
    logic [a_lo_size-1:0]    winner;
    logic [a_lo_size-1:0]    sel;
    logic [3:0]              word_cnt;
    logic [hw-1:0]           hold_cnt [nr_of_queues];
    logic [0:nr_of_queues-1] eligible;
    logic [0:nr_of_queues-1] sel_oh;
    logic                    found;
    logic                    pop;
    logic                    last_pop;
    logic                    enter_last;
    logic                    go;
    logic                    read_adr_r;
    logic                    read_data_r;
    logic [0:nr_of_queues-1] read_enable_r;
    logic [rd_lat-1:0]       pv;
    logic [rd_lat-1:0]       pl;
    logic [a_lo_size-1:0]    pq [rd_lat];

    always_comb begin
        for (int i = 0; i < nr_of_queues; i++)
            eligible[i] = bus.enable & bus.ready[i] & ~bus.fifo_empty[i] & (hold_cnt[i] == '0);
    end

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= nr_of_queues; k++) begin
            idx = (int'(ptr) + k) % nr_of_queues;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = a_lo_size'(idx);
            end
        end
        for (int i = 0; i < nr_of_queues; i++)
            sel_oh[i] = (sel == a_lo_size'(i));
    end

    // word_cnt holds L-1 from grant until DATA starts counting it down
    assign pop        = (state == AWAIT) || (state == DATA);
    assign last_pop   = ((state == AWAIT) && (word_cnt == 4'd0)) ||
                        ((state == DATA)  && (word_cnt == 4'd1));
    assign enter_last = ((state == ADR)   && (word_cnt == 4'd0)) ||
                        ((state == AWAIT) && (word_cnt == 4'd1)) ||
                        ((state == DATA)  && (word_cnt == 4'd2));
    // the final pop cycle doubles as the arbitration point so grants can chain
    assign go         = ((state == IDLE) || last_pop) && found;

    always_ff @(posedge clk2 or posedge rst2) begin
        if (rst2) begin
            state         <= IDLE;
            ptr           <= a_lo_size'(nr_of_queues - 1);
            winner        <= '0;
            word_cnt      <= 4'd0;
            read_adr_r    <= 1'b0;
            read_data_r   <= 1'b0;
            read_enable_r <= '0;
        end else if (go) begin
            state         <= ADR;
            ptr           <= sel;
            winner        <= sel;
            word_cnt      <= bus.fifo_flag[sel] ? 4'(burst_len - 1) : 4'd0;
            read_adr_r    <= 1'b1;
            read_data_r   <= 1'b0;
            read_enable_r <= sel_oh;
        end else begin
            read_adr_r <= 1'b0;
            case (state)
                IDLE: begin
                    read_data_r   <= 1'b0;
                    read_enable_r <= '0;
                end
                ADR: begin
                    state       <= AWAIT;
                    read_data_r <= 1'b0;
                end
                AWAIT: begin
                    if (word_cnt != 4'd0) begin
                        state       <= DATA;
                        read_data_r <= 1'b1;
                    end else begin
                        state         <= IDLE;
                        read_data_r   <= 1'b0;
                        read_enable_r <= '0;
                    end
                end
                DATA: begin
                    if (word_cnt == 4'd1) begin
                        state         <= IDLE;
                        read_data_r   <= 1'b0;
                        read_enable_r <= '0;
                    end else begin
                        word_cnt    <= word_cnt - 4'd1;
                        read_data_r <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    read_data_r   <= 1'b0;
                    read_enable_r <= '0;
                end
            endcase
        end
    end

    // loading on entry to the final pop keeps the winner masked while it arbitrates
    always_ff @(posedge clk2 or posedge rst2) begin
        if (rst2) begin
            for (int i = 0; i < nr_of_queues; i++)
                hold_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < nr_of_queues; i++) begin
                if (enter_last && (winner == a_lo_size'(i)))
                    hold_cnt[i] <= hw'(holdoff);
                else if (hold_cnt[i] != '0)
                    hold_cnt[i] <= hold_cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk2 or posedge rst2) begin
        if (rst2) begin
            pv <= '0;
            pl <= '0;
            for (int k = 0; k < rd_lat; k++)
                pq[k] <= '0;
        end else begin
            pv[0] <= pop;
            pl[0] <= last_pop;
            pq[0] <= winner;
            for (int k = 1; k < rd_lat; k++) begin
                pv[k] <= pv[k-1];
                pl[k] <= pl[k-1];
                pq[k] <= pq[k-1];
            end
        end
    end

    assign bus.read_adr    = read_adr_r;
    assign bus.read_data   = read_data_r;
    assign bus.read_enable = read_enable_r;
    assign bus.q_valid     = pv[rd_lat-1];
    assign bus.q_last      = pl[rd_lat-1];
    assign bus.q_queue     = pq[rd_lat-1];
    assign bus.busy        = (state != IDLE) || (|pv);
endmodule

// File: tb/tb_egress_read_sched.sv
// Directed bench for egress_read_sched: 4 queues, burst_len 4, rd_lat 2, holdoff 3.
module tb_egress_read_sched;
    logic clk2 = 1'b0;
    logic rst2 = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic       tr_adr  [64];
    logic       tr_dat  [64];
    logic [0:3] tr_en   [64];
    logic       tr_qv   [64];
    logic [1:0] tr_qq   [64];
    logic       tr_ql   [64];
    logic       tr_busy [64];

    egress_read_sched_if #(.nr_of_queues(4), .a_lo_size(2)) bus ();

    egress_read_sched #(
        .nr_of_queues(4), .a_lo_size(2), .burst_len(4), .rd_lat(2), .holdoff(3)
    ) dut (
        .clk2(clk2),
        .rst2(rst2),
        .bus (bus.master)
    );

    always #5 clk2 = ~clk2;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk2);
            #1;
        end
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk2);
            #1;
            tr_adr[i]  = bus.read_adr;
            tr_dat[i]  = bus.read_data;
            tr_en[i]   = bus.read_enable;
            tr_qv[i]   = bus.q_valid;
            tr_qq[i]   = bus.q_queue;
            tr_ql[i]   = bus.q_last;
            tr_busy[i] = bus.busy;
        end
    endtask

    function automatic int first_adr(input int n);
        for (int i = 0; i < n; i++)
            if (tr_adr[i] === 1'b1) return i;
        return -1;
    endfunction

    task automatic do_reset;
        rst2           = 1'b1;
        bus.enable     = 1'b0;
        bus.fifo_empty = 4'b1111;
        bus.fifo_flag  = 4'b0000;
        bus.ready      = 4'b0000;
        step(2);
        rst2 = 1'b0;
    endtask

    task automatic wait_adr(input string name, output bit ok);
        int w = 0;
        while (bus.read_adr !== 1'b1 && w < 12) begin
            step(1);
            w++;
        end
        ok = (bus.read_adr === 1'b1);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_grant_timeout got=no read_adr exp=read_adr within 12 cycles", name);
        end
    endtask

    task automatic test_reset;
        rst2           = 1'b1;
        bus.enable     = 1'b1;
        bus.fifo_empty = 4'b0000;
        bus.fifo_flag  = 4'b1111;
        bus.ready      = 4'b1111;
        step(3);
        checks++;
        if ({bus.read_adr, bus.read_data, bus.q_valid, bus.q_last} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=0000", {bus.read_adr, bus.read_data, bus.q_valid, bus.q_last});
        end
        checks++;
        if (bus.read_enable !== 4'b0000 || bus.q_queue !== 2'd0) begin
            failures++;
            $display("FAIL reset_vectors got_en=%b got_q=%0d exp=0", bus.read_enable, bus.q_queue);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_single_queue;
        int t;
        int n;
        do_reset();
        bus.enable     = 1'b1;
        bus.fifo_empty = 4'b1101;
        bus.ready      = 4'b0010;
        bus.fifo_flag  = 4'b0010;
        capture(24);
        t = first_adr(8);
        checks++;
        if (t < 0) begin
            failures++;
            $display("FAIL single_grant got=none exp=read_adr");
            return;
        end
        checks++;
        if (tr_en[t] !== 4'b0010) begin
            failures++;
            $display("FAIL single_read_enable got=%b exp=0010", tr_en[t]);
        end
        checks++;
        if (tr_dat[t+1] !== 1'b0) begin
            failures++;
            $display("FAIL single_await_data got=%b exp=0", tr_dat[t+1]);
        end
        for (int k = 2; k <= 5; k++) begin
            checks++;
            if (tr_dat[t+k] !== (k <= 4)) begin
                failures++;
                $display("FAIL single_read_data_t%0d got=%b exp=%b", k, tr_dat[t+k], (k <= 4));
            end
        end
        for (int k = 2; k <= 7; k++) begin
            checks++;
            if (tr_qv[t+k] !== (k >= 3 && k <= 6) || tr_ql[t+k] !== (k == 6) ||
                ((k >= 3 && k <= 6) && tr_qq[t+k] !== 2'd2)) begin
                failures++;
                $display("FAIL single_sideband_t%0d got=v%b l%b q%0d exp=v%b l%b q2",
                         k, tr_qv[t+k], tr_ql[t+k], tr_qq[t+k], (k >= 3 && k <= 6), (k == 6));
            end
        end
        checks++;
        if (tr_en[t+5] !== 4'b0000) begin
            failures++;
            $display("FAIL single_idle_enable got=%b exp=0000", tr_en[t+5]);
        end
        n = 0;
        for (int k = 1; k <= 7; k++) n += int'(tr_adr[t+k]);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL single_holdoff_mask got=%0d read_adr exp=0", n);
        end
        checks++;
        if (tr_adr[t+8] !== 1'b1) begin
            failures++;
            $display("FAIL single_regrant_t8 got=%b exp=1", tr_adr[t+8]);
        end
    endtask

    task automatic test_round_robin;
        int         t;
        int         ord [6] = '{0, 1, 3, 0, 1, 3};
        logic [0:3] exp_en;
        do_reset();
        bus.enable     = 1'b1;
        bus.fifo_empty = 4'b0010;
        bus.ready      = 4'b1111;
        bus.fifo_flag  = 4'b0000;
        capture(24);
        t = first_adr(8);
        checks++;
        if (t < 0) begin
            failures++;
            $display("FAIL rr_grant got=none exp=read_adr");
            return;
        end
        for (int g = 0; g < 6; g++) begin
            exp_en = 4'b1000 >> ord[g];
            checks++;
            if (tr_adr[t+2*g] !== 1'b1 || tr_adr[t+2*g+1] !== 1'b0 || tr_en[t+2*g] !== exp_en) begin
                failures++;
                $display("FAIL rr_grant%0d got=adr%b%b en=%b exp=adr10 en=%b",
                         g, tr_adr[t+2*g], tr_adr[t+2*g+1], tr_en[t+2*g], exp_en);
            end
            checks++;
            if (tr_qv[t+2*g+3] !== 1'b1 || tr_ql[t+2*g+3] !== 1'b1 ||
                tr_qq[t+2*g+3] !== 2'(ord[g]) || tr_qv[t+2*g+4] !== 1'b0) begin
                failures++;
                $display("FAIL rr_word%0d got=v%b l%b q%0d next_v%b exp=v1 l1 q%0d next_v0",
                         g, tr_qv[t+2*g+3], tr_ql[t+2*g+3], tr_qq[t+2*g+3], tr_qv[t+2*g+4], ord[g]);
            end
        end
    endtask

    task automatic test_mixed_length;
        int   nv = 0;
        int   both = 0;
        int   exp_q [5] = '{0, 0, 0, 0, 1};
        logic exp_l [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0] got_q [5];
        logic       got_l [5];
        do_reset();
        bus.enable     = 1'b1;
        bus.fifo_empty = 4'b0011;
        bus.ready      = 4'b1111;
        bus.fifo_flag  = 4'b1000;
        capture(24);
        for (int i = 0; i < 24; i++) begin
            if (tr_adr[i] === 1'b1 && tr_dat[i] === 1'b1) both++;
            if (tr_qv[i] === 1'b1 && nv < 5) begin
                got_q[nv] = tr_qq[i];
                got_l[nv] = tr_ql[i];
                nv++;
            end
        end
        checks++;
        if (both != 0) begin
            failures++;
            $display("FAIL mixed_adr_data_overlap got=%0d exp=0", both);
        end
        checks++;
        if (nv < 5) begin
            failures++;
            $display("FAIL mixed_word_count got=%0d exp=5", nv);
            return;
        end
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (got_q[j] !== 2'(exp_q[j]) || got_l[j] !== exp_l[j]) begin
                failures++;
                $display("FAIL mixed_word%0d got=q%0d l%b exp=q%0d l%b",
                         j, got_q[j], got_l[j], exp_q[j], exp_l[j]);
            end
        end
    endtask

    task automatic test_mid_burst_drop;
        bit ok;
        int nqv = 0;
        int nql = 0;
        int nadr = 0;
        int ndat = 0;
        do_reset();
        bus.enable     = 1'b1;
        bus.fifo_empty = 4'b0111;
        bus.ready      = 4'b1000;
        bus.fifo_flag  = 4'b1000;
        wait_adr("drop", ok);
        if (!ok) return;
        step(2);
        checks++;
        if (bus.read_data !== 1'b1) begin
            failures++;
            $display("FAIL drop_in_data got=%b exp=1", bus.read_data);
        end
        bus.enable = 1'b0;
        bus.ready  = 4'b0000;
        capture(12);
        for (int i = 0; i < 12; i++) begin
            nqv  += int'(tr_qv[i]);
            nql  += int'(tr_ql[i]);
            nadr += int'(tr_adr[i]);
            ndat += int'(tr_dat[i]);
        end
        checks++;
        if (nqv != 4 || nql != 1) begin
            failures++;
            $display("FAIL drop_words got=v%0d l%0d exp=v4 l1", nqv, nql);
        end
        checks++;
        if (ndat != 2) begin
            failures++;
            $display("FAIL drop_remaining_data got=%0d exp=2", ndat);
        end
        checks++;
        if (nadr != 0 || tr_busy[11] !== 1'b0) begin
            failures++;
            $display("FAIL drop_no_regrant got=adr%0d busy%b exp=adr0 busy0", nadr, tr_busy[11]);
        end
    endtask

    task automatic test_reset_mid_burst;
        bit ok;
        int nqv = 0;
        do_reset();
        bus.enable     = 1'b1;
        bus.fifo_empty = 4'b0111;
        bus.ready      = 4'b1000;
        bus.fifo_flag  = 4'b1000;
        wait_adr("rstmid", ok);
        if (!ok) return;
        step(3);
        checks++;
        if (bus.read_data !== 1'b1 || bus.q_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_before got=d%b v%b exp=d1 v1", bus.read_data, bus.q_valid);
        end
        rst2 = 1'b1;
        #1;
        checks++;
        if ({bus.read_adr, bus.read_data, bus.q_valid, bus.q_last, bus.busy} !== 5'b0 ||
            bus.read_enable !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_async got=%b en=%b exp=00000 en=0000",
                     {bus.read_adr, bus.read_data, bus.q_valid, bus.q_last, bus.busy}, bus.read_enable);
        end
        bus.fifo_empty = 4'b0000;
        bus.ready      = 4'b1111;
        bus.fifo_flag  = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step(1);
            nqv += int'(bus.q_valid);
        end
        checks++;
        if (nqv != 0) begin
            failures++;
            $display("FAIL rstmid_flushed got=%0d q_valid exp=0", nqv);
        end
        rst2 = 1'b0;
        wait_adr("rstmid_restart", ok);
        if (!ok) return;
        checks++;
        if (bus.read_enable !== 4'b1000) begin
            failures++;
            $display("FAIL rstmid_restart_q0 got=%b exp=1000", bus.read_enable);
        end
    endtask

    task automatic test_no_eligible;
        int nadr;
        int nbusy;
        for (int sc = 0; sc < 3; sc++) begin
            do_reset();
            case (sc)
                0: begin bus.enable = 1'b1; bus.fifo_empty = 4'b1111; bus.ready = 4'b1111; end
                1: begin bus.enable = 1'b1; bus.fifo_empty = 4'b0000; bus.ready = 4'b0000; end
                default: begin bus.enable = 1'b0; bus.fifo_empty = 4'b0000; bus.ready = 4'b1111; end
            endcase
            bus.fifo_flag = 4'b1111;
            capture(16);
            nadr  = 0;
            nbusy = 0;
            for (int i = 0; i < 16; i++) begin
                nadr  += int'(tr_adr[i]);
                nbusy += int'(tr_busy[i]);
            end
            checks++;
            if (nadr != 0 || nbusy != 0) begin
                failures++;
                $display("FAIL idle_case%0d got=adr%0d busy%0d exp=adr0 busy0", sc, nadr, nbusy);
            end
        end
    endtask

    initial begin
        bus.enable     = 1'b0;
        bus.fifo_empty = 4'b1111;
        bus.fifo_flag  = 4'b0000;
        bus.ready      = 4'b0000;
        test_reset();
        test_single_queue();
        test_round_robin();
        test_mixed_length();
        test_mid_burst_drop();
        test_reset_mid_burst();
        test_no_eligible();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
